// File: rtl/radix2_booth_divider_seq_if.sv
// Start/done handshake and operand/result bus of the sequential signed divider.
// master drives requests; slave is the divider.
interface radix2_booth_divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             divByZero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, quotient, remainder, done, divByZero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, quotient, remainder, done, divByZero, overflow
  );
endinterface

// File: rtl/radix2_booth_divider_seq.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit per clock.
// Latency WIDTH+1 cycles start to done (1 cycle for divide-by-zero / MIN_INT/-1); start ignored while busy.
module radix2_booth_divider_seq #(
  parameter int WIDTH = 32
) (
  input logic                      clk,
  input logic                      reset,
  radix2_booth_divider_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag;
  logic             sign_dd;
  logic             sign_dv;
  logic             bypass;
  logic             dz_pend;
  logic             ov_pend;

  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic             dv_zero;
  logic             ovf_case;
  logic [WIDTH:0]   trial;

  // Magnitudes are unsigned, so |MIN_INT| = 2^(WIDTH-1) is represented exactly.
  assign dd_mag   = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dv_mag   = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
  assign dv_zero  = (bus.divisor == '0);
  assign ovf_case = (bus.dividend == MIN_INT) && (bus.divisor == '1);

  // The partial remainder never exceeds the divisor magnitude, so WIDTH bits hold it;
  // the extra trial bit is the borrow that decides restore vs. keep.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_mag};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      count         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_mag       <= '0;
      sign_dd       <= 1'b0;
      sign_dv       <= 1'b0;
      bypass        <= 1'b0;
      dz_pend       <= 1'b0;
      ov_pend       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.divByZero <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sign_dd       <= bus.dividend[WIDTH-1];
            sign_dv       <= bus.divisor[WIDTH-1];
            dvs_mag       <= dv_mag;
            count         <= '0;
            bus.busy      <= 1'b1;
            bus.divByZero <= 1'b0;
            bus.overflow  <= 1'b0;
            dz_pend       <= 1'b0;
            ov_pend       <= 1'b0;
            if (dv_zero) begin
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              bypass  <= 1'b1;
              dz_pend <= 1'b1;
              state   <= S_FIX;
            end else if (ovf_case) begin
              quo_q   <= MIN_INT;
              rem_q   <= '0;
              bypass  <= 1'b1;
              ov_pend <= 1'b1;
              state   <= S_FIX;
            end else begin
              quo_q  <= dd_mag;
              rem_q  <= '0;
              bypass <= 1'b0;
              state  <= S_ITER;
            end
          end
        end

        S_ITER: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          if (bypass) begin
            bus.quotient  <= quo_q;
            bus.remainder <= rem_q;
          end else begin
            bus.quotient  <= (sign_dd ^ sign_dv) ? (~quo_q + 1'b1) : quo_q;
            bus.remainder <= sign_dd ? (~rem_q + 1'b1) : rem_q;
          end
          bus.divByZero <= dz_pend;
          bus.overflow  <= ov_pend;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_radix2_booth_divider_seq.sv
// Scoreboard bench for the sequential signed divider: expected results queued at accepted start,
// popped and compared when done pulses.
module tb_radix2_booth_divider_seq;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic         dz;
    logic         ov;
    int           lat;
    int           t0;
  } exp_t;

  logic clk;
  logic reset;
  int   cycle;
  int   errors;
  int   checks;
  exp_t sb[$];

  radix2_booth_divider_seq_if #(.WIDTH(W)) bus ();

  radix2_booth_divider_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    e.dd  = dd;
    e.dv  = dv;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.lat = 1;
    e.t0  = 0;
    if (dv == '0) begin
      e.q  = '1;
      e.r  = dd;
      e.dz = 1'b1;
    end else if (dd == MIN_INT && dv == '1) begin
      e.q  = MIN_INT;
      e.r  = '0;
      e.ov = 1'b1;
    end else begin
      e.q   = $signed(dd) / $signed(dv);
      e.r   = $signed(dd) % $signed(dv);
      e.lat = W + 1;
    end
    return e;
  endfunction

  // Result monitor: sampled on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        logic [W-1:0] rmag;
        logic [W-1:0] dmag;
        e = sb.pop_front();
        check("quotient",  64'(bus.quotient),  64'(e.q));
        check("remainder", 64'(bus.remainder), 64'(e.r));
        check("divByZero", 64'(bus.divByZero), 64'(e.dz));
        check("overflow",  64'(bus.overflow),  64'(e.ov));
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("latency", 64'(cycle - e.t0), 64'(e.lat));
        if (!e.dz && !e.ov) begin
          check("identity", 64'(W'(bus.quotient * e.dv + bus.remainder)), 64'(e.dd));
          rmag = bus.remainder[W-1] ? -bus.remainder : bus.remainder;
          dmag = e.dv[W-1] ? -e.dv : e.dv;
          check("rem_bound", 64'(rmag < dmag), 64'd1);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic expect_accept);
    exp_t e;
    @(negedge clk);
    check("accept_ready", 64'(!bus.busy), 64'(expect_accept));
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    #1;
    if (expect_accept) begin
      e    = model(dd, dv);
      e.t0 = cycle;
      sb.push_back(e);
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  logic [W-1:0] tbl_dd[10];
  logic [W-1:0] tbl_dv[10];

  initial begin
    errors       = 0;
    checks       = 0;
    cycle        = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q",    64'(bus.quotient), 64'd0);
    check("rst_r",    64'(bus.remainder), 64'd0);
    check("rst_flags", 64'({bus.divByZero, bus.overflow}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 100 / 7 with busy observed one cycle after acceptance
    issue(32'd100, 32'd7, 1'b1);
    @(negedge clk);
    check("busy_c1", 64'(bus.busy), 64'd1);
    check("done_c1", 64'(bus.done), 64'd0);
    wait_drain(60);

    tbl_dd = '{-32'sd100, 32'd100, -32'sd100, 32'h1234_5678, MIN_INT, MIN_INT, 32'd0, 32'd7, -32'sd1, 32'h7FFF_FFFF};
    tbl_dv = '{32'd7, -32'sd7, -32'sd7, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd100, MIN_INT, 32'h7FFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      issue(tbl_dd[i], tbl_dv[i], 1'b1);
      wait_drain(60);
    end

    // Second start while busy is ignored
    issue(32'd50, 32'd3, 1'b1);
    repeat (3) @(posedge clk);
    issue(32'd9, 32'd2, 1'b0);
    wait_drain(60);

    // Back-to-back: new start in the cycle done is high
    issue(32'd100, 32'd7, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
    end
    check("b2b_done_seen", 64'(bus.done), 64'd1);
    issue(32'd9, 32'd2, 1'b1);
    @(negedge clk);
    check("b2b_done_drop", 64'(bus.done), 64'd0);
    check("b2b_q_held", 64'(bus.quotient), 64'd14);
    wait_drain(60);

    // Reset in the middle of an operation
    issue(32'd1000, 32'd3, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_q",    64'(bus.quotient), 64'd0);
    check("mid_rst_r",    64'(bus.remainder), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", 64'(bus.busy), 64'd0);

    // Random signed pairs
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom();
      case (i % 3)
        0: b = $urandom();
        1: b = W'($urandom_range(1, 300));
        default: b = -W'($urandom_range(1, 300));
      endcase
      if (i % 4 == 1) a = a >> $urandom_range(0, 28);
      issue(a, b, 1'b1);
      wait_drain(60);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
